hssl_vio_ctl: RTL

- Receives the VIO probe_out control levels, which are written asynchronously from JTAG, and turns them into clean, clk-synchronous control for the GTH/HSSL block.
- Rising edges of reset requests become fixed-width reset pulses.
- Loopback selection is applied only after its value has been stable, and each change automatically triggers an RX datapath reset.
- Sits between the VIO instance and the GTH wrapper/HSSL interface, in the transceiver user clock domain.

---
 rtl/hssl_vio_pkg.sv | 22 ++
 rtl/bit_synchronizer.sv | 20 ++
 rtl/hssl_vio_pulse.sv | 53 +++++
 rtl/hssl_vio_ctl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/hssl_vio_pkg.sv
// hssl_vio_pkg: shared types and constants for the VIO -> GTH/HSSL control block.
package hssl_vio_pkg;

    localparam int LB_W    = 3;
    localparam int NUM_RST = 6;

    // Index of each reset request in the per-request vectors.
    localparam int RST_ALL    = 0;
    localparam int RST_TX_PLL = 1;
    localparam int RST_TX     = 2;
    localparam int RST_RX_PLL = 3;
    localparam int RST_RX     = 4;
    localparam int RST_HSSL   = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        APPLY    = 2'd2,
        WAIT_RST = 2'd3
    } lb_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: two-flop synchroniser for one asynchronous level.
// Deliberately has no reset so the chain keeps tracking the VIO level while
// rst_n is low; a level held high across reset is then already settled at
// release and the edge detector behind it sees no rise.
module bit_synchronizer (
    input  logic clk,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

    // Shift the async level through the two metastability flops.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/hssl_vio_pulse.sv
// hssl_vio_pulse: one reset request channel. Synchronises the VIO level,
// detects its rising edge and stretches it (or a local launch) into a
// PULSE_LEN-cycle pulse. A new trigger reloads the counter.
module hssl_vio_pulse #(
    parameter int PULSE_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vio_i,
    input  logic launch_i,
    output logic rise_o,
    output logic pulse_o
);

    localparam int            CW   = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);

    logic          sync;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    (* DONT_TOUCH = "TRUE" *)
    bit_synchronizer u_sync (
        .clk (clk),
        .d_i (vio_i),
        .q_o (sync)
    );

    assign rise_o  = sync & ~prev_q;
    assign pulse_o = (cnt_q != '0);

    // Reload on any trigger, otherwise count down to zero and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_o || launch_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // prev resets high so a level already asserted at reset does not fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            prev_q <= sync;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/hssl_vio_ctl.sv
// hssl_vio_ctl: turns asynchronous VIO probe_out levels into clean
// clk-synchronous reset pulses and a debounced loopback select for the GTH.
// Optional request counter on req_cnt is built only when
// HSSL_VIO_CTL_CNT_EN is defined; otherwise req_cnt is tied to zero.
module hssl_vio_ctl
    import hssl_vio_pkg::*;
#(
    parameter int PULSE_LEN     = 16,
    parameter int STABLE_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vio_reset_all,
    input  logic             vio_reset_tx_pll_dp,
    input  logic             vio_reset_tx_dp,
    input  logic             vio_reset_rx_pll_dp,
    input  logic             vio_reset_rx_dp,
    input  logic             vio_reset_hssl,
    input  logic [LB_W-1:0]  vio_loopback,
    output logic             reset_all_out,
    output logic             reset_tx_pll_dp_out,
    output logic             reset_tx_dp_out,
    output logic             reset_rx_pll_dp_out,
    output logic             reset_rx_dp_out,
    output logic             reset_hssl_out,
    output logic [LB_W-1:0]  loopback_out,
    output logic             busy,
    output logic [CNT_W-1:0] req_cnt
);

    localparam int            SW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] ST_LAST = SW'(STABLE_CYCLES - 1);

    logic [NUM_RST-1:0] vio_req, rise, pulse, launch;
    logic [LB_W-1:0]    sync_lb;
    lb_state_e          state_q, state_d;
    logic [LB_W-1:0]    lb_q, lb_d, cand_q, cand_d;
    logic [SW-1:0]      st_cnt_q, st_cnt_d;

    assign vio_req[RST_ALL]    = vio_reset_all;
    assign vio_req[RST_TX_PLL] = vio_reset_tx_pll_dp;
    assign vio_req[RST_TX]     = vio_reset_tx_dp;
    assign vio_req[RST_RX_PLL] = vio_reset_rx_pll_dp;
    assign vio_req[RST_RX]     = vio_reset_rx_dp;
    assign vio_req[RST_HSSL]   = vio_reset_hssl;

    hssl_vio_pulse #(.PULSE_LEN(PULSE_LEN)) u_pulse [NUM_RST-1:0] (
        .clk      (clk),
        .rst_n    (rst_n),
        .vio_i    (vio_req),
        .launch_i (launch),
        .rise_o   (rise),
        .pulse_o  (pulse)
    );

    (* DONT_TOUCH = "TRUE" *)
    bit_synchronizer u_lb_sync [LB_W-1:0] (
        .clk (clk),
        .d_i (vio_loopback),
        .q_o (sync_lb)
    );

    // reset_all dominates: every other reset is held while it is active.
    assign reset_all_out       = pulse[RST_ALL];
    assign reset_tx_pll_dp_out = pulse[RST_TX_PLL] | pulse[RST_ALL];
    assign reset_tx_dp_out     = pulse[RST_TX]     | pulse[RST_ALL];
    assign reset_rx_pll_dp_out = pulse[RST_RX_PLL] | pulse[RST_ALL];
    assign reset_rx_dp_out     = pulse[RST_RX]     | pulse[RST_ALL];
    assign reset_hssl_out      = pulse[RST_HSSL]   | pulse[RST_ALL];
    assign loopback_out        = lb_q;
    assign busy                = (|pulse) || (state_q != IDLE);

    // Loopback FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lb_q     <= '0;
            cand_q   <= '0;
            st_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lb_q     <= lb_d;
            cand_q   <= cand_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    // Next state: a candidate must hold STABLE_CYCLES cycles before APPLY.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        st_cnt_d = st_cnt_q;
        case (state_q)
            IDLE: begin
                st_cnt_d = '0;
                if (sync_lb != lb_q) begin
                    state_d = SETTLE;
                    cand_d  = sync_lb;
                end
            end
            SETTLE: begin
                if (sync_lb == lb_q) begin
                    state_d  = IDLE;
                    st_cnt_d = '0;
                end else if (sync_lb != cand_q) begin
                    cand_d   = sync_lb;
                    st_cnt_d = '0;
                end else begin
                    st_cnt_d = st_cnt_q + SW'(1);
                    if (st_cnt_d >= ST_LAST) state_d = APPLY;
                end
            end
            APPLY:    state_d = WAIT_RST;
            WAIT_RST: if (!reset_rx_dp_out) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs: APPLY commits the candidate and relaunches the RX datapath reset.
    always_comb begin
        lb_d   = lb_q;
        launch = '0;
        if (state_q == APPLY) begin
            lb_d           = cand_q;
            launch[RST_RX] = 1'b1;
        end
    end

`ifdef HSSL_VIO_CTL_CNT_EN
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W+2:0] sum;

    // Add up to NUM_RST VIO rises per cycle, saturating at all-ones.
    always_comb begin
        sum = {3'b000, req_cnt_q};
        for (int i = 0; i < NUM_RST; i++) begin
            sum = sum + {{(CNT_W+2){1'b0}}, rise[i]};
        end
        req_cnt_d = (sum > {3'b000, {CNT_W{1'b1}}}) ? '1 : sum[CNT_W-1:0];
    end

    // Request counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_cnt_q <= '0;
        else        req_cnt_q <= req_cnt_d;
    end

    assign req_cnt = req_cnt_q;
`else
    logic unused_rise;
    assign unused_rise = ^rise;
    assign req_cnt     = '0;
`endif

endmodule
